raiz_controle: RTL and testbench

RAIZ_CONTROLE -- requirements
Module: raiz_controle

---
 rtl/raiz_controle.sv | 113 +++++++++++
 tb/tb_raiz_controle.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/raiz_controle.sv
// Control FSM for an iterative integer square-root datapath (odd-number accumulation).
// Optional watchdog abort is compiled in with `define RAIZ_CTRL_WATCHDOG_EN.
module raiz_controle #(
    parameter int MAX_ITER = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       positive,
    output logic [8:0] controler,
    output logic       busy,
    output logic       valid,
    output logic [7:0] iter,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CMP   = 3'd2,
        S_INC_D = 3'd3,
        S_INC_S = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Control word bit order: selD selS enD enS enR enX selA selB cin.
    localparam logic [8:0] WORD_IDLE  = 9'h000;
    localparam logic [8:0] WORD_INIT  = 9'h1E8;
    localparam logic [8:0] WORD_CMP   = 9'h005;
    localparam logic [8:0] WORD_INC_D = 9'h052;
    localparam logic [8:0] WORD_INC_S = 9'h021;
    localparam logic [8:0] WORD_DONE  = 9'h000;

    localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);
    localparam logic [7:0] ITER_SAT   = 8'hFF;

`ifdef RAIZ_CTRL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    state_t state;
    state_t state_next;
    logic   wd_fire;
    logic   init_entry;

    // Watchdog abort: CMP still negative after MAX_ITER completed loops.
    assign wd_fire    = WD_EN && (state == S_CMP) && !positive && (iter == ITER_LIMIT);
    assign init_entry = (state_next == S_INIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_INIT;
            S_INIT:  state_next = S_CMP;
            S_CMP:   state_next = (positive || wd_fire) ? S_DONE : S_INC_D;
            S_INC_D: state_next = S_INC_S;
            S_INC_S: state_next = S_CMP;
            S_DONE:  state_next = start ? S_INIT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        controler = WORD_IDLE;
        busy      = 1'b0;
        valid     = 1'b0;
        case (state)
            S_IDLE:  controler = WORD_IDLE;
            S_INIT:  begin controler = WORD_INIT;  busy = 1'b1; end
            S_CMP:   begin controler = WORD_CMP;   busy = 1'b1; end
            S_INC_D: begin controler = WORD_INC_D; busy = 1'b1; end
            S_INC_S: begin controler = WORD_INC_S; busy = 1'b1; end
            S_DONE:  begin controler = WORD_DONE;  valid = 1'b1; end
            default: controler = WORD_IDLE;
        endcase
    end

    // A loop counts as completed on the INC_S -> CMP transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            iter <= 8'd0;
        end else if (init_entry) begin
            iter <= 8'd0;
        end else if ((state == S_INC_S) && (iter != ITER_SAT)) begin
            iter <= iter + 8'd1;
        end
    end

`ifdef RAIZ_CTRL_WATCHDOG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (init_entry) begin
            err <= 1'b0;
        end else if (wd_fire) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_raiz_controle.sv
// Self-checking bench for raiz_controle: randomized runs compared against a cycle-schedule model.
module tb_raiz_controle;

    localparam int MAX_ITER = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       positive;
    logic [8:0] controler;
    logic       busy;
    logic       valid;
    logic [7:0] iter;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;
    int last_iter   = 0;
    bit last_err    = 1'b0;

    raiz_controle #(.MAX_ITER(MAX_ITER)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .positive  (positive),
        .controler (controler),
        .busy      (busy),
        .valid     (valid),
        .iter      (iter),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Phase codes: 0 idle, 1 init, 2 compare, 3 step D, 4 step S, 5 done.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int ph);
        case (ph)
            1:       return 32'h1E8;
            2:       return 32'h005;
            3:       return 32'h052;
            4:       return 32'h021;
            default: return 32'h000;
        endcase
    endfunction

    // Phase of cycle c (c=1 follows the start edge) of a run that completes k loops.
    function automatic int phase_of(input int c, input int k);
        if (c == 1) return 1;
        if (c == 3 + 3 * k) return 5;
        case ((c - 2) % 3)
            0:       return 2;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check_cycle(input int ph, input int exp_iter, input bit exp_err);
        check("controler", 32'(controler), word_of(ph));
        check("busy",      32'(busy),      32'(ph >= 1 && ph <= 4));
        check("valid",     32'(valid),     32'(ph == 5));
        check("iter",      32'(iter),      32'(exp_iter));
        check("err",       32'(err),       32'(exp_err));
    endtask

    // Caller has already set start=1 for the coming edge. Returns at the negedge
    // of the DONE cycle, or right after checking cycle stop_at when nonzero.
    task automatic do_run(input int k, input bit hold, input bit wd_abort, input int stop_at);
        int ph;
        int exp_iter;
        bit exp_err;
        for (int c = 1; c <= 3 + 3 * k; c++) begin
            @(negedge clock);
            ph       = phase_of(c, k);
            exp_iter = (c < 2) ? 0 : (c - 2) / 3;
            if (exp_iter > 255) exp_iter = 255;
            exp_err  = (ph == 5) && wd_abort;
            check_cycle(ph, exp_iter, exp_err);
            last_iter = exp_iter;
            last_err  = exp_err;
            if (c == stop_at) return;
            if (c < 3 + 3 * k) begin
                start = hold ? 1'b1 : 1'($urandom_range(0, 1));
                if (ph == 2) positive = (c == 2 + 3 * k) && !wd_abort;
                else         positive = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start    = 1'b0;
            positive = 1'($urandom_range(0, 1));
            @(negedge clock);
            check_cycle(0, last_iter, last_err);
        end
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        start    = 1'b1;
        positive = 1'b1;
        last_iter = 0;
        last_err  = 1'b0;
        @(negedge clock);
        check_cycle(0, 0, 1'b0);
        @(negedge clock);
        check_cycle(0, 0, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check_cycle(0, 0, 1'b0);
    endtask

    task automatic begin_run();
        start    = 1'b1;
        positive = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int k;
        reset    = 1'b1;
        start    = 1'b0;
        positive = 1'b0;
        @(negedge clock);
        check_cycle(0, 0, 1'b0);
        @(negedge clock);
        check_cycle(0, 0, 1'b0);
        reset = 1'b0;
        idle_cycles(2);

        // Zero-iteration run, then two iterations.
        begin_run();
        do_run(0, 1'b0, 1'b0, 0);
        idle_cycles(1);
        begin_run();
        do_run(2, 1'b0, 1'b0, 0);
        idle_cycles(1);

        // start held high: ignored while busy, back-to-back restart from DONE.
        begin_run();
        do_run(2, 1'b1, 1'b0, 0);
        do_run(0, 1'b1, 1'b0, 0);
        idle_cycles(1);

        for (int r = 0; r < 14; r++) begin
`ifdef RAIZ_CTRL_WATCHDOG_EN
            k = $urandom_range(0, MAX_ITER);
`else
            k = $urandom_range(0, 6);
`endif
            begin_run();
            do_run(k, 1'($urandom_range(0, 1)), 1'b0, 0);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(1);

        // positive held low through every compare.
        begin_run();
`ifdef RAIZ_CTRL_WATCHDOG_EN
        do_run(MAX_ITER, 1'b0, 1'b1, 0);
        idle_cycles(2);
        begin_run();
        do_run(1, 1'b0, 1'b0, 0);
        idle_cycles(1);
`else
        do_run(20, 1'b0, 1'b0, 40);
        apply_reset();
`endif

        // Reset asserted for two cycles in the middle of an INC_S cycle.
        begin_run();
        do_run(3, 1'b0, 1'b0, 4);
        apply_reset();
        begin_run();
        do_run(1, 1'b0, 1'b0, 0);
        idle_cycles(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
